// File: rtl/capture_pkg.sv
// capture_pkg
//   Shared definitions for the APB logic-capture block: register word
//   addresses, CTRL/STATUS bit positions and the capture FSM encoding.
//   No ports; imported by apb_capture_fifo.
package capture_pkg;

  // Register word addresses (PADDR is a word index, one register each)
  localparam int ADDR_CTRL   = 0;
  localparam int ADDR_STATUS = 1;
  localparam int ADDR_COUNT  = 2;
  localparam int ADDR_DATA   = 3;
  localparam int ADDR_MATCH  = 4;
  localparam int ADDR_MASK   = 5;
  localparam int ADDR_DIV    = 6;

  // CTRL bit positions
  localparam int CTRL_ARM  = 0;
  localparam int CTRL_CLR  = 1;
  localparam int CTRL_MODE = 2;
  localparam int CTRL_CONT = 3;

  // STATUS bit positions
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_ARMED = 2;
  localparam int ST_TRIG  = 3;
  localparam int ST_OVF   = 4;

  // Capture FSM. STATUS.ARMED/TRIGGERED together identify the state,
  // so the state is always visible to the host through STATUS.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } cap_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with flush and a registered head-of-queue output.
//   o_rdata always holds the oldest entry (undefined when empty), so a
//   reader can present it without a memory read in the pop cycle.
// Ports
//   clk, rst_n    clock, synchronous active-low reset
//   i_push/i_wdata  enqueue; ignored when full unless popping same cycle
//   i_pop         dequeue; ignored when empty
//   i_flush       empty the FIFO; overrides push and pop
//   o_rdata       head entry
//   o_full, o_empty, o_count  occupancy (count is 0..DEPTH)
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [DW-1:0]              i_wdata,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [DW-1:0]              o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_rdata;

  logic          w_do_push;
  logic          w_do_pop;
  logic [PW-1:0] w_rd_next;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_rdata;

  // A full FIFO still accepts a push when an entry leaves the same cycle.
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
  assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;
  assign w_rd_next = r_rd_ptr + PW'(w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= w_rd_next;
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
      // Next head: bypass the write when it lands on the new head slot
      // (FIFO was empty, or drains to the entry being written).
      if (w_do_push && (r_wr_ptr == w_rd_next)) r_rdata <= i_wdata;
      else                                      r_rdata <= r_mem[w_rd_next];
    end
  end

endmodule

// File: rtl/apb_capture_fifo.sv
// apb_capture_fifo
//   APB target that samples an 8-bit debug bus into a FIFO after a
//   programmable trigger (immediate or masked match), one-shot or
//   continuous, with a programmable sample divider. Host drains DATA.
// Ports
//   clk, rst_n                       clock, synchronous active-low reset
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA   APB request
//   PRDATA, PREADY                   APB response
//   sample_in                        capture source (already in clk domain)
//   irq                              level: capture done or overflow
module apb_capture_fifo
  import capture_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = 8,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          PSEL,
  input  logic [AW-1:0] PADDR,
  input  logic          PENABLE,
  input  logic          PWRITE,
  input  logic [DW-1:0] PWDATA,
  output logic [DW-1:0] PRDATA,
  output logic          PREADY,
  input  logic [DW-1:0] sample_in,
  output logic          irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  cap_state_e    r_state;
  cap_state_e    w_state_nxt;
  logic          r_wait;
  logic          r_mode;
  logic          r_cont;
  logic          r_ovf;
  logic [DW-1:0] r_match;
  logic [DW-1:0] r_mask;
  logic [DW-1:0] r_div;
  logic [DW-1:0] r_div_cnt;

  logic          w_access;
  logic          w_wr;
  logic          w_ctrl_wr;
  logic          w_clr;
  logic          w_data_rd;
  logic          w_pop;
  logic          w_push;
  logic          w_set_ovf;
  logic          w_div_restart;
  logic          w_tick;
  logic          w_match;
  logic          w_armed;
  logic          w_trig;
  logic [DW-1:0] w_fifo_rdata;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;

  // Handshake: a transfer completes on the clock edge where
  // PSEL & PENABLE & PREADY are all high. Only DATA reads stall: the first
  // access cycle drives PREADY=0 (r_wait set), the second completes and pops.
  assign w_access  = PSEL & PENABLE;
  assign w_wr      = w_access & PWRITE;
  assign w_ctrl_wr = w_wr & (PADDR == AW'(ADDR_CTRL));
  assign w_clr     = w_ctrl_wr & PWDATA[CTRL_CLR];
  assign w_data_rd = w_access & ~PWRITE & (PADDR == AW'(ADDR_DATA));
  assign PREADY    = ~(w_data_rd & ~r_wait);
  assign w_pop     = w_data_rd & r_wait;

  assign w_tick  = (r_div_cnt == r_div);
  assign w_match = (((sample_in ^ r_match) & r_mask) == '0);
  assign w_armed = (r_state == S_ARMED) || (r_state == S_CAPTURE);
  assign w_trig  = (r_state == S_CAPTURE) || (r_state == S_DONE);
  assign irq     = (r_state == S_DONE) | r_ovf;

  sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (sample_in),
    .i_pop   (w_pop),
    .i_flush (w_clr),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // CTRL writes take precedence over capture activity in the same cycle;
  // CLR beats everything, then disarm, then arm from IDLE/DONE.
  always_comb begin
    w_state_nxt   = r_state;
    w_push        = 1'b0;
    w_set_ovf     = 1'b0;
    w_div_restart = 1'b0;
    if (w_clr) begin
      w_state_nxt = S_IDLE;
    end else if (w_ctrl_wr && !PWDATA[CTRL_ARM]) begin
      w_state_nxt = S_IDLE;
    end else if (w_ctrl_wr && ((r_state == S_IDLE) || (r_state == S_DONE))) begin
      w_state_nxt   = S_ARMED;
      w_div_restart = 1'b1;
    end else begin
      case (r_state)
        S_ARMED: begin
          if (w_tick && (!r_mode || w_match)) begin
            w_state_nxt = S_CAPTURE;
            w_push      = 1'b1;
          end
        end
        S_CAPTURE: begin
          if (w_tick) begin
            if (w_fifo_full && !w_pop) begin
              if (r_cont) w_set_ovf   = 1'b1;
              else        w_state_nxt = S_DONE;
            end else begin
              w_push = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wait    <= 1'b0;
      r_mode    <= 1'b0;
      r_cont    <= 1'b0;
      r_ovf     <= 1'b0;
      r_match   <= '0;
      r_mask    <= '0;
      r_div     <= '0;
      r_div_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_data_rd & ~r_wait;
      if (w_div_restart || w_tick) r_div_cnt <= '0;
      else                         r_div_cnt <= r_div_cnt + DW'(1);
      if (w_clr)          r_ovf <= 1'b0;
      else if (w_set_ovf) r_ovf <= 1'b1;
      if (w_wr) begin
        case (PADDR)
          AW'(ADDR_CTRL): begin
            r_mode <= PWDATA[CTRL_MODE];
            r_cont <= PWDATA[CTRL_CONT];
          end
          AW'(ADDR_MATCH): r_match <= PWDATA;
          AW'(ADDR_MASK):  r_mask  <= PWDATA;
          AW'(ADDR_DIV):   r_div   <= PWDATA;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (PADDR)
        AW'(ADDR_CTRL): begin
          PRDATA[CTRL_ARM]  = w_armed;
          PRDATA[CTRL_MODE] = r_mode;
          PRDATA[CTRL_CONT] = r_cont;
        end
        AW'(ADDR_STATUS): begin
          PRDATA[ST_EMPTY] = w_fifo_empty;
          PRDATA[ST_FULL]  = w_fifo_full;
          PRDATA[ST_ARMED] = w_armed;
          PRDATA[ST_TRIG]  = w_trig;
          PRDATA[ST_OVF]   = r_ovf;
        end
        AW'(ADDR_COUNT): PRDATA = DW'(w_fifo_count);
        AW'(ADDR_DATA):  PRDATA = w_fifo_empty ? '0 : w_fifo_rdata;
        AW'(ADDR_MATCH): PRDATA = r_match;
        AW'(ADDR_MASK):  PRDATA = r_mask;
        AW'(ADDR_DIV):   PRDATA = r_div;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_capture_fifo.sv
// tb_apb_capture_fifo
//   Directed sequence with random sample data. The expected FIFO contents
//   are derived from which clock edges should capture (arm edge, divider
//   period, trigger rule) and the sample value recorded for each edge.
module tb_apb_capture_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       PSEL = 1'b0;
  logic [4:0] PADDR = '0;
  logic       PENABLE = 1'b0;
  logic       PWRITE = 1'b0;
  logic [7:0] PWDATA = '0;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic [7:0] sample_in = '0;
  logic       irq;

  apb_capture_fifo #(.DEPTH(16), .DW(8), .AW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .PSEL      (PSEL),
    .PADDR     (PADDR),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .sample_in (sample_in),
    .irq       (irq)
  );

  // ---------------- clock / cycle index ----------------
  always #5 clk = ~clk;

  int cyc = 0;  // number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- sample source ----------------
  // samp[k] is the value sample_in holds at rising edge k.
  logic [7:0] samp [0:8191];
  int         gen_mode = 0;  // 0 random, 1 ramp
  logic [7:0] ramp_v = '0;
  always @(negedge clk) begin
    if (gen_mode == 1) begin
      sample_in = ramp_v;
      ramp_v    = ramp_v + 8'd1;
    end else begin
      sample_in = 8'($urandom);
    end
    if (cyc < 8191) samp[cyc + 1] = sample_in;
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int last_commit = 0;
  int last_rd = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_status(int n, bit armed, bit trig, bit ovf);
    return {3'b000, ovf, trig, armed, (n == 16), (n == 0)};
  endfunction

  // ---------------- APB driver tasks ----------------
  task automatic apb_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(negedge clk);
    PENABLE = 1'b1;
    last_commit = cyc + 1;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [4:0] a, output logic [7:0] d, output int waits);
    @(negedge clk);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    @(negedge clk);
    PENABLE = 1'b1;
    waits = 0;
    d = '0;
    #1;
    while (!PREADY && waits < 8) begin
      waits++;
      @(negedge clk);
      #1;
    end
    if (PREADY) begin
      d = PRDATA;
      last_rd = cyc + 1;
    end else begin
      check("pready_timeout", PREADY, 1);
    end
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [4:0] a, input logic [7:0] exp);
    logic [7:0] d;
    int w;
    apb_read(a, d, w);
    check(tag, d, exp);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] d;
    logic [7:0] e;
    int w;
    apb_read(5'h03, d, w);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    check(tag, d, e);
    check({tag, "_waits"}, w, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] d;
    logic [7:0] r8;
    int w;
    int a;
    int b;
    int k;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_pready", PREADY, 1);
    check("rst_irq", irq, 0);
    check("rst_prdata", PRDATA, 0);
    rst_n = 1'b1;
    rd_check("rst_ctrl", 5'h00, 8'h00);
    rd_check("rst_status", 5'h01, 8'h01);
    rd_check("rst_count", 5'h02, 8'h00);
    rd_check("rst_match", 5'h04, 8'h00);
    rd_check("rst_mask", 5'h05, 8'h00);
    rd_check("rst_div", 5'h06, 8'h00);
    apb_read(5'h03, d, w);
    check("rst_data_empty", d, 0);
    check("rst_data_waits", w, 1);
    rd_check("rst_count_after_empty_read", 5'h02, 8'h00);

    // Register read/write, read-only and unmapped addresses
    r8 = 8'($urandom); apb_write(5'h04, r8); rd_check("match_rw", 5'h04, r8);
    r8 = 8'($urandom); apb_write(5'h05, r8); rd_check("mask_rw", 5'h05, r8);
    r8 = 8'($urandom); apb_write(5'h06, r8); rd_check("div_rw", 5'h06, r8);
    apb_write(5'h1F, 8'($urandom)); rd_check("unmapped_read", 5'h1F, 8'h00);
    apb_write(5'h01, 8'hFF); rd_check("status_ro", 5'h01, 8'h01);
    apb_write(5'h00, 8'h0C); rd_check("ctrl_mode_cont", 5'h00, 8'h0C);
    apb_write(5'h00, 8'h00);
    apb_write(5'h06, 8'h00);

    // One-shot immediate capture, DIV=0: 16 consecutive edges after arm
    apb_write(5'h00, 8'h01);
    a = last_commit;
    repeat (20) @(negedge clk);
    for (int e = a + 1; e <= a + 16; e++) exp_q.push_back(samp[e]);
    #1;
    check("s2_irq_done", irq, 1);
    rd_check("s2_count", 5'h02, 8'd16);
    rd_check("s2_status", 5'h01, exp_status(16, 0, 1, 0));
    rd_check("s2_ctrl_arm_readback", 5'h00, 8'h00);
    for (int i = 0; i < 16; i++) pop_check("s2_pop");
    pop_check("s2_pop_empty");
    rd_check("s2_count_drained", 5'h02, 8'h00);

    // Masked match trigger on a ramp
    apb_write(5'h04, 8'hA5);
    apb_write(5'h05, 8'hF0);
    gen_mode = 1;
    ramp_v = 8'h00;
    apb_write(5'h00, 8'h05);
    a = last_commit;
    repeat (200) @(negedge clk);
    k = a + 1;
    while (k < cyc && (((samp[k] ^ 8'hA5) & 8'hF0) != 8'h00)) k++;
    for (int j = 0; j < 16; j++) exp_q.push_back(samp[k + j]);
    gen_mode = 0;
    rd_check("s3_status_trig", 5'h01, exp_status(16, 0, 1, 0));
    apb_read(5'h03, d, w);
    check("s3_first_pop", d, 8'hA0);
    check("s3_first_model", d, exp_q.pop_front());
    for (int i = 0; i < 15; i++) pop_check("s3_pop");

    // Divided tick (DIV=3), then disarm mid-capture
    apb_write(5'h00, 8'h02);
    apb_write(5'h06, 8'h03);
    apb_write(5'h00, 8'h01);
    a = last_commit;
    repeat (13) @(negedge clk);
    while (((cyc + 3 - a) % 4) == 0) @(negedge clk);
    apb_write(5'h00, 8'h00);
    b = last_commit;
    for (int e = a + 4; e < b; e += 4) exp_q.push_back(samp[e]);
    rd_check("s4_count_at_disarm", 5'h02, 8'(exp_q.size()));
    repeat (12) @(negedge clk);
    rd_check("s4_count_frozen", 5'h02, 8'(exp_q.size()));
    rd_check("s4_status_idle", 5'h01, exp_status(exp_q.size(), 0, 0, 0));
    #1;
    check("s4_irq", irq, 0);
    while (exp_q.size() > 0) pop_check("s4_pop");

    // Continuous capture with overflow, pop concurrent with tick
    apb_write(5'h00, 8'h02);
    apb_write(5'h06, 8'h00);
    apb_write(5'h00, 8'h09);
    a = last_commit;
    repeat (22) @(negedge clk);
    for (int e = a + 1; e <= a + 16; e++) exp_q.push_back(samp[e]);
    #1;
    check("s5_irq_ovf", irq, 1);
    rd_check("s5_count_full", 5'h02, 8'd16);
    rd_check("s5_status", 5'h01, exp_status(16, 1, 1, 1));
    for (int i = 0; i < 3; i++) begin
      pop_check("s5_pop_refill");
      exp_q.push_back(samp[last_rd]);
      rd_check("s5_count_kept", 5'h02, 8'd16);
    end
    apb_write(5'h00, 8'h08);
    rd_check("s5_status_idle", 5'h01, exp_status(16, 0, 0, 1));
    while (exp_q.size() > 0) pop_check("s5_pop");
    #1;
    check("s5_irq_sticky", irq, 1);

    // CLR during a continuous capture with data waiting to be read
    apb_write(5'h00, 8'h09);
    a = last_commit;
    repeat (4) @(negedge clk);
    exp_q.push_back(samp[a + 1]);
    pop_check("s6_pop_before_clr");
    apb_write(5'h00, 8'h02);
    exp_q.delete();
    rd_check("s6_count", 5'h02, 8'h00);
    rd_check("s6_status", 5'h01, 8'h01);
    #1;
    check("s6_irq", irq, 0);
    repeat (5) @(negedge clk);
    rd_check("s6_count_idle", 5'h02, 8'h00);

    // Reset while a DATA read is stalled
    apb_write(5'h00, 8'h01);
    repeat (5) @(negedge clk);
    apb_write(5'h00, 8'h00);
    @(negedge clk);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = 5'h03; PENABLE = 1'b0;
    @(negedge clk);
    PENABLE = 1'b1;
    #1;
    check("s7_stall", PREADY, 0);
    rst_n = 1'b0;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0;
    rst_n = 1'b1;
    #1;
    check("s7_pready_after_rst", PREADY, 1);
    check("s7_irq_after_rst", irq, 0);
    rd_check("s7_status", 5'h01, 8'h01);
    rd_check("s7_count", 5'h02, 8'h00);
    rd_check("s7_match", 5'h04, 8'h00);
    apb_read(5'h03, d, w);
    check("s7_data_empty", d, 0);
    check("s7_data_waits", w, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
